// File: rtl/core_pipe_pkg.sv
// Shared definitions for the RV32I pipeline stage registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int ALU_CTRL_W = 4;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Control bundle carried from decode into execute.
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } ex_ctrl_t;

  // A bubble carries no side effects.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in E whose rd is read by the instruction in D.
// Latency: purely combinational.
// Backpressure: none; the result feeds the stall request and bubble insert.
module load_use_detect
  import core_pipe_pkg::*;
(
  input  logic       valid_e,
  input  logic       mem_read_e,
  input  logic [4:0] rd_e,
  input  logic       valid_d,
  input  logic       use_rs1_d,
  input  logic       use_rs2_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  output logic       load_use
);

  logic load_in_e;
  logic rs1_hit;
  logic rs2_hit;

  // A load to x0 never produces a value worth waiting for.
  assign load_in_e = valid_e & mem_read_e & (rd_e != REG_X0);
  assign rs1_hit   = use_rs1_d & (rs1_d == rd_e);
  assign rs2_hit   = use_rs2_d & (rs2_d == rd_e);
  assign load_use  = load_in_e & valid_d & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with built-in load-use interlock (optional counters: ID_EX_PERF_CNT_EN).
// Latency: 1 cycle D->E; stall_d is combinational from E state and D inputs.
// Backpressure: stall_e holds E, flush_e bubbles E, load-use bubbles E and asks D to freeze.
module id_ex_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int XLEN       = core_pipe_pkg::XLEN,
  parameter int ALU_CTRL_W = core_pipe_pkg::ALU_CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  valid_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [4:0]            rs1_d,
  input  logic [4:0]            rs2_d,
  input  logic [4:0]            rd_d,
  input  logic                  use_rs1_d,
  input  logic                  use_rs2_d,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       imm_d,
  input  logic                  reg_write_d,
  input  logic                  mem_read_d,
  input  logic                  mem_write_d,
  input  logic                  alu_src_d,
  input  logic                  branch_d,
  input  logic                  jump_d,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl_d,
  output logic                  stall_d,
  output logic                  valid_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [4:0]            rs1_e,
  output logic [4:0]            rs2_e,
  output logic [4:0]            rd_e,
  output logic [XLEN-1:0]       rd1_e,
  output logic [XLEN-1:0]       rd2_e,
  output logic [XLEN-1:0]       imm_e,
  output logic                  reg_write_e,
  output logic                  mem_read_e,
  output logic                  mem_write_e,
  output logic                  alu_src_e,
  output logic                  branch_e,
  output logic                  jump_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           bubble_cnt_o,
  output logic [31:0]           hold_cnt_o
`endif
);

  ex_ctrl_t ctrl_d;
  ex_ctrl_t ctrl_q;
  logic     load_use;

  // Control of an invalid decode slot is forced inert before capture.
  always_comb begin
    ctrl_d = EX_CTRL_BUBBLE;
    if (valid_d) begin
      ctrl_d.reg_write = reg_write_d;
      ctrl_d.mem_read  = mem_read_d;
      ctrl_d.mem_write = mem_write_d;
      ctrl_d.alu_src   = alu_src_d;
      ctrl_d.branch    = branch_d;
      ctrl_d.jump      = jump_d;
      ctrl_d.alu_ctrl  = alu_ctrl_d;
    end
  end

  load_use_detect u_load_use_detect (
    .valid_e    (valid_e),
    .mem_read_e (ctrl_q.mem_read),
    .rd_e       (rd_e),
    .valid_d    (valid_d),
    .use_rs1_d  (use_rs1_d),
    .use_rs2_d  (use_rs2_d),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .load_use   (load_use)
  );

  // A flush kills whatever would stall D, so it also releases the freeze.
  assign stall_d = rst_n & ~flush_e & (load_use | stall_e);

  // E register bank: flush > hold > load-use bubble > capture D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e <= 1'b0;
      pc_e    <= '0;
      rs1_e   <= REG_X0;
      rs2_e   <= REG_X0;
      rd_e    <= REG_X0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
      ctrl_q  <= EX_CTRL_BUBBLE;
    end else if (flush_e || (!stall_e && load_use)) begin
      valid_e <= 1'b0;
      pc_e    <= '0;
      rs1_e   <= REG_X0;
      rs2_e   <= REG_X0;
      rd_e    <= REG_X0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
      ctrl_q  <= EX_CTRL_BUBBLE;
    end else if (!stall_e) begin
      valid_e <= valid_d;
      pc_e    <= pc_d;
      rs1_e   <= rs1_d;
      rs2_e   <= rs2_d;
      rd_e    <= rd_d;
      rd1_e   <= rd1_d;
      rd2_e   <= rd2_d;
      imm_e   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign reg_write_e = ctrl_q.reg_write;
  assign mem_read_e  = ctrl_q.mem_read;
  assign mem_write_e = ctrl_q.mem_write;
  assign alu_src_e   = ctrl_q.alu_src;
  assign branch_e    = ctrl_q.branch;
  assign jump_e      = ctrl_q.jump;
  assign alu_ctrl_e  = ctrl_q.alu_ctrl;

`ifdef ID_EX_PERF_CNT_EN
  // Count inserted load-use bubbles and held cycles; both wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
      hold_cnt_o   <= '0;
    end else begin
      if (!flush_e && !stall_e && load_use) bubble_cnt_o <= bubble_cnt_o + 32'd1;
      if (!flush_e && stall_e)              hold_cnt_o   <= hold_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver pushes expectations, monitor pops and compares.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm;
    logic        rw, mr, mw, as, br, jp;
    logic [3:0]  alu;
  } e_t;

  typedef struct packed {
    e_t   e;
    logic u1, u2;
  } d_t;

  typedef struct packed {
    e_t          st;
    logic [31:0] bc, hc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_e = 1'b0, flush_e = 1'b0;
  logic valid_d = 1'b0;
  logic [31:0] pc_d = '0, rd1_d = '0, rd2_d = '0, imm_d = '0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic use_rs1_d = 1'b0, use_rs2_d = 1'b0;
  logic reg_write_d = 1'b0, mem_read_d = 1'b0, mem_write_d = 1'b0;
  logic alu_src_d = 1'b0, branch_d = 1'b0, jump_d = 1'b0;
  logic [3:0] alu_ctrl_d = '0;

  logic stall_d, valid_e;
  logic [31:0] pc_e, rd1_e, rd2_e, imm_e;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e;
  logic [3:0] alu_ctrl_e;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_o, hold_cnt_o;
`endif

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .reg_write_d(reg_write_d), .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
    .alu_src_d(alu_src_d), .branch_d(branch_d), .jump_d(jump_d), .alu_ctrl_d(alu_ctrl_d),
    .stall_d(stall_d), .valid_e(valid_e), .pc_e(pc_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e), .alu_ctrl_e(alu_ctrl_e)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  exp_t state_q[$];
  logic stall_q[$];

  // Reference model state: what E should hold, and the two event counts.
  e_t          m_e = '0;
  logic [31:0] m_bc = '0, m_hc = '0;

  function automatic logic hazard(input e_t e, input d_t d);
    if (!(e.valid && e.mr && e.rd != 5'd0 && d.e.valid)) return 1'b0;
    return (d.u1 && d.e.rs1 == e.rd) || (d.u2 && d.e.rs2 == e.rd);
  endfunction

  function automatic e_t capture(input d_t d);
    e_t e;
    e = d.e;
    if (!e.valid) begin
      e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.as = 1'b0;
      e.br = 1'b0; e.jp = 1'b0; e.alu = 4'd0;
    end
    return e;
  endfunction

  function automatic d_t mk(input logic v, input logic [4:0] r1, r2, rd,
                            input logic u1, u2, mr, rw);
    d_t d;
    d = '0;
    d.e.valid = v; d.e.rs1 = r1; d.e.rs2 = r2; d.e.rd = rd;
    d.u1 = u1; d.u2 = u2; d.e.mr = mr; d.e.rw = rw;
    d.e.pc = 32'h1000 + {27'd0, rd} * 4;
    d.e.rd1 = 32'hA000_0000 | r1; d.e.rd2 = 32'hB000_0000 | r2; d.e.imm = 32'h0000_0040;
    d.e.alu = 4'd2;
    return d;
  endfunction

  function automatic d_t rnd_d();
    d_t d;
    d.e.valid = ($urandom_range(0, 99) < 85);
    d.e.pc  = $urandom; d.e.rd1 = $urandom; d.e.rd2 = $urandom; d.e.imm = $urandom;
    d.e.rs1 = 5'($urandom_range(0, 7));
    d.e.rs2 = 5'($urandom_range(0, 7));
    d.e.rd  = 5'($urandom_range(0, 7));
    d.e.rw = 1'($urandom); d.e.mr = 1'($urandom); d.e.mw = 1'($urandom);
    d.e.as = 1'($urandom); d.e.br = 1'($urandom); d.e.jp = 1'($urandom);
    d.e.alu = 4'($urandom);
    d.u1 = 1'($urandom); d.u2 = 1'($urandom);
    return d;
  endfunction

  logic last_stall = 1'b0;

  // One cycle: drive inputs after negedge, push expected stall_d now and E after next edge.
  task automatic step(input d_t d, input logic st, input logic fl, input logic rst);
    exp_t nx;
    logic sexp;
    @(negedge clk);
    #1;
    rst_n = rst; stall_e = st; flush_e = fl;
    valid_d = d.e.valid; pc_d = d.e.pc; rs1_d = d.e.rs1; rs2_d = d.e.rs2; rd_d = d.e.rd;
    use_rs1_d = d.u1; use_rs2_d = d.u2;
    rd1_d = d.e.rd1; rd2_d = d.e.rd2; imm_d = d.e.imm;
    reg_write_d = d.e.rw; mem_read_d = d.e.mr; mem_write_d = d.e.mw;
    alu_src_d = d.e.as; branch_d = d.e.br; jump_d = d.e.jp; alu_ctrl_d = d.e.alu;
    if (!rst) begin
      // Asynchronous: E is cleared right now, not at the next edge.
      m_e = '0; m_bc = '0; m_hc = '0;
      if (state_q.size() > 0) state_q[state_q.size()-1] = '0;
      sexp = 1'b0;
    end else begin
      sexp = !fl && (hazard(m_e, d) || st);
      if (fl) m_e = '0;
      else if (st) m_hc = m_hc + 32'd1;
      else if (hazard(m_e, d)) begin
        m_e = '0;
        m_bc = m_bc + 32'd1;
      end else m_e = capture(d);
    end
    nx.st = m_e; nx.bc = m_bc; nx.hc = m_hc;
    stall_q.push_back(sexp);
    state_q.push_back(nx);
    last_stall = sexp;
  endtask

  // Monitor: between input change and the next edge, compare DUT against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (state_q.size() > 0) begin
        exp_t x;
        e_t a;
        x = state_q.pop_front();
        a = '{valid_e, pc_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_e,
              reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e, alu_ctrl_e};
        checks++;
        if (a !== x.st) begin
          failures++;
          $display("FAIL e_state t=%0t act=%h exp=%h", $time, a, x.st);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (bubble_cnt_o !== x.bc || hold_cnt_o !== x.hc) begin
          failures++;
          $display("FAIL perf_cnt t=%0t act=%0d/%0d exp=%0d/%0d",
                   $time, bubble_cnt_o, hold_cnt_o, x.bc, x.hc);
        end
`endif
      end
      if (stall_q.size() > 0) begin
        logic s;
        s = stall_q.pop_front();
        checks++;
        if (stall_d !== s) begin
          failures++;
          $display("FAIL stall_d t=%0t act=%b exp=%b", $time, stall_d, s);
        end
      end
    end
  end

  initial begin
    d_t d;
    d_t cur_d;
    state_q.push_back('0);
    // Reset held with random D and stall_e: E stays empty, stall_d stays low.
    for (int i = 0; i < 4; i++) step(rnd_d(), 1'($urandom), 1'b0, 1'b0);
    // add x3,x1,x2 right after release.
    step(mk(1, 1, 2, 3, 1, 1, 0, 1), 0, 0, 1);
    // lw x5 then dependent add x6,x5,x7 (re-presented while stalled).
    step(mk(1, 4, 0, 5, 1, 0, 1, 1), 0, 0, 1);
    d = mk(1, 5, 7, 6, 1, 1, 0, 1);
    step(d, 0, 0, 1);
    step(d, 0, 0, 1);
    // lw x0 then reader of x0; lw x5 then rs2=x5 with use_rs2 low.
    step(mk(1, 1, 0, 0, 1, 0, 1, 1), 0, 0, 1);
    step(mk(1, 0, 0, 8, 1, 1, 0, 1), 0, 0, 1);
    step(mk(1, 1, 0, 5, 1, 0, 1, 1), 0, 0, 1);
    step(mk(1, 1, 5, 9, 1, 0, 0, 1), 0, 0, 1);
    // Hold three cycles, then flush together with hold.
    d = mk(1, 2, 3, 4, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(d, 1, 0, 1);
    step(d, 1, 1, 1);
    // Load-use under hold: two held cycles, then one bubble, then the dependent op.
    step(mk(1, 1, 0, 5, 1, 0, 1, 1), 0, 0, 1);
    d = mk(1, 2, 5, 10, 0, 1, 0, 1);
    step(d, 1, 0, 1);
    step(d, 1, 0, 1);
    step(d, 0, 0, 1);
    step(d, 0, 0, 1);
    // Reset asserted while a load-use stall is pending.
    step(mk(1, 1, 0, 6, 1, 0, 1, 1), 0, 0, 1);
    d = mk(1, 6, 0, 7, 1, 0, 0, 1);
    step(d, 0, 0, 0);
    step(d, 0, 0, 1);
    step(d, 0, 0, 1);
    // Random traffic; D re-presents while stall_d is expected, as IF/ID would.
    cur_d = rnd_d();
    for (int i = 0; i < 3000; i++) begin
      logic st, fl, rs;
      if (!last_stall) cur_d = rnd_d();
      st = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 99) < 8);
      rs = ($urandom_range(0, 999) >= 5);
      step(cur_d, st, fl, rs);
    end
    @(negedge clk);
    #5;
    checks++;
    if (state_q.size() != 0 || stall_q.size() != 0) begin
      failures++;
      $display("FAIL drain act=%0d/%0d exp=0/0", state_q.size(), stall_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
